// File: rtl/reg_bank_load_ctrl.sv
// Load/compute sequencer for a PE register bank: streams NUM_REGS words into one-hot strobed
// registers, then holds compute_en for a programmed count. Optional macro: REG_LOAD_TIMEOUT_EN.
module reg_bank_load_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS   = 3,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned TO_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  compute_len_i,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] reg_in_o,
   output logic [NUM_REGS-1:0]   set_reg_o,
   output logic                  compute_en_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDone} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  compute_en_q, compute_en_d;
   logic                  done_q, done_d;
   logic                  fire;
   logic                  timeout;

   assign in_ready_o = (state_q == StLoad);
   assign fire       = in_valid_i & in_ready_o;
   assign reg_in_o   = in_data_i;
   assign set_reg_o  = fire ? (NUM_REGS'(1) << idx_q) : '0;

`ifdef REG_LOAD_TIMEOUT_EN
   localparam logic [TO_WIDTH-1:0] ToMax = '1;

   logic [TO_WIDTH-1:0] to_q, to_d;
   logic                err_q;

   // Counter is held at zero outside LOAD, so it is already clear on entry.
   always_comb begin
      to_d = to_q;
      if (!in_ready_o || fire) begin
         to_d = '0;
      end else begin
         to_d = to_q + TO_WIDTH'(1);
      end
   end

   assign timeout = in_ready_o & ~fire & (to_q == ToMax);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= timeout;
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               len_d   = compute_len_i;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (fire) begin
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = StCompute;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end else if (timeout) begin
               idx_d   = '0;
               state_d = StIdle;
            end
         end
         StCompute: begin
            // A zero length still spends one cycle here, with compute_en low.
            if ((len_q == '0) || (cnt_q == len_q - CNT_WIDTH'(1))) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      compute_en_d = (state_d == StCompute) && (len_q != '0);
      done_d       = (state_d == StDone);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         compute_en_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         compute_en_q <= compute_en_d;
         done_q       <= done_d;
      end
   end

   assign compute_en_o = compute_en_q;
   assign done_o       = done_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_reg_bank_load_ctrl.sv
// Bench for reg_bank_load_ctrl: a timeline model of each pass checked every cycle, plus directed
// passes with hand-computed latencies, compute counts and register-bank contents.
module tb_reg_bank_load_ctrl;

   localparam int DW    = 16;
   localparam int NR    = 3;
   localparam int CW    = 8;
   localparam int ToMax = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] compute_len;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [DW-1:0] reg_in;
   logic [NR-1:0] set_reg;
   logic          compute_en;
   logic          busy;
   logic          done;
   logic          err;

   reg_bank_load_ctrl #(
      .DATA_WIDTH(DW),
      .NUM_REGS  (NR),
      .CNT_WIDTH (CW),
      .TO_WIDTH  (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .compute_len_i(compute_len),
      .in_valid_i   (in_valid),
      .in_data_i    (in_data),
      .in_ready_o   (in_ready),
      .reg_in_o     (reg_in),
      .set_reg_o    (set_reg),
      .compute_en_o (compute_en),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pass timeline model: a pass accepted at cycle t_acc loads NR words on valid cycles, the
   // last at t_last; compute_en covers t_last+1..t_last+len; done follows one cycle later.
   int            cyc = 0;
   bit            pass = 0;
   int            t_acc, t_last, fires, mlen, to_cnt, pass_ce;
   bit            err_pend = 0;
   int            last_ce = -1;
   int            last_lat = -1;
   logic [DW-1:0] bank [NR];

   always @(negedge clk) begin
      bit            loading, e_ce, e_done, e_busy;
      logic [NR-1:0] e_set;
      int            hold;
      if (rst) begin
         pass     = 0;
         err_pend = 0;
         check("rst_busy", busy, 0);
         check("rst_ready", in_ready, 0);
         check("rst_set", set_reg, 0);
         check("rst_ce", compute_en, 0);
         check("rst_done", done, 0);
         check("rst_err", err, 0);
      end else begin
         loading = pass && (fires < NR);
         hold    = (mlen == 0) ? 1 : mlen;
         e_set   = (loading && in_valid) ? (NR'(1) << fires) : '0;
         e_busy  = pass;
         e_ce    = pass && (fires == NR) && (mlen != 0) && (cyc > t_last) && (cyc <= t_last + mlen);
         e_done  = pass && (fires == NR) && (cyc == t_last + hold + 1);
         check("in_ready", in_ready, loading);
         check("set_reg", set_reg, e_set);
         check("reg_in", reg_in, in_data);
         check("busy", busy, e_busy);
         check("compute_en", compute_en, e_ce);
         check("done", done, e_done);
         check("err", err, err_pend);
         for (int k = 0; k < NR; k++) if (set_reg[k]) bank[k] = reg_in;
         if (e_ce) pass_ce++;
         err_pend = 0;
         if (loading) begin
            if (in_valid) begin
               fires++;
               to_cnt = 0;
               if (fires == NR) t_last = cyc;
            end else begin
`ifdef REG_LOAD_TIMEOUT_EN
               if (to_cnt == ToMax) begin
                  pass     = 0;
                  err_pend = 1;
               end else begin
                  to_cnt++;
               end
`endif
            end
         end
         if (e_done) begin
            pass     = 0;
            last_ce  = pass_ce;
            last_lat = cyc - t_acc;
         end else if (!e_busy && start) begin
            pass    = 1;
            t_acc   = cyc;
            mlen    = int'(compute_len);
            fires   = 0;
            to_cnt  = 0;
            pass_ce = 0;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen = 0;
      int i = 0;
      while (!seen && i < bound) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
         i++;
      end
      check(name, seen, 1);
      step();
   endtask

   // vpat bit i gives in_valid for the i-th cycle after start; words go out on valid cycles.
   task automatic load(input logic [CW-1:0] len, input logic [15:0] vpat, input int nvp,
                       input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2);
      logic [DW-1:0] w [NR];
      int wi = 0;
      w[0] = w0; w[1] = w1; w[2] = w2;
      start       = 1'b1;
      compute_len = len;
      step();
      start = 1'b0;
      for (int i = 0; i < nvp; i++) begin
         in_valid = vpat[i];
         in_data  = vpat[i] ? w[wi] : 16'hdead;
         if (vpat[i]) wi++;
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; compute_len = '0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_ready", in_ready, 0);
      check("reset_set", set_reg, 0);
      check("reset_ce", compute_en, 0);
      check("reset_done", done, 0);
      repeat (2) step();
      rst = 1'b0;
      step();

      // Basic pass: words 5,-7,100, len 4 -> done 3+4+1 cycles after start.
      load(8'd4, 16'b111, 3, 16'd5, 16'hfff9, 16'd100);
      wait_done("basic_done_seen", 40);
      check("basic_ce_cycles", last_ce, 4);
      check("basic_latency", last_lat, 8);
      check("basic_bank0", bank[0], 16'd5);
      check("basic_bank1", bank[1], 16'hfff9);
      check("basic_bank2", bank[2], 16'd100);
      check("basic_busy_after", busy, 0);

      // Backpressure 1,0,0,1,0,1 with len 1: last fire at T+6, done at T+8.
      load(8'd1, 16'b101001, 6, 16'd11, 16'd22, 16'd33);
      wait_done("bp_done_seen", 40);
      check("bp_ce_cycles", last_ce, 1);
      check("bp_latency", last_lat, 8);
      check("bp_bank0", bank[0], 16'd11);
      check("bp_bank1", bank[1], 16'd22);
      check("bp_bank2", bank[2], 16'd33);

      // Zero length: compute_en never rises, done at NR+2.
      load(8'd0, 16'b111, 3, 16'd1, 16'd2, 16'd3);
      wait_done("len0_done_seen", 40);
      check("len0_ce_cycles", last_ce, 0);
      check("len0_latency", last_lat, 5);

      // start held high; compute_len changed mid-pass only affects the next pass.
      start = 1'b1; compute_len = 8'd2; in_valid = 1'b1; in_data = 16'h0044;
      step(); step();
      compute_len = 8'd9;
      wait_done("held_done1_seen", 40);
      check("held_ce1", last_ce, 2);
      check("held_lat1", last_lat, 6);
      check("held_idle_gap", busy, 0);
      step();
      check("held_restart", busy, 1);
      start = 1'b0;
      wait_done("held_done2_seen", 40);
      check("held_ce2", last_ce, 9);
      check("held_lat2", last_lat, 13);
      in_valid = 1'b0;
      step();

      // Async reset after the second fire drops outputs before any clock edge.
      start = 1'b1; compute_len = 8'd3; in_valid = 1'b1; in_data = 16'd7;
      step();
      start = 1'b0; in_data = 16'd8;
      step();
      in_data = 16'd9;
      step();
      check("pre_rst_ready", in_ready, 1);
      check("pre_rst_set", set_reg, 3'b100);
      #2 rst = 1'b1;
      #1;
      check("arst_ready", in_ready, 0);
      check("arst_set", set_reg, 0);
      check("arst_busy", busy, 0);
      check("arst_ce", compute_en, 0);
      step();
      rst = 1'b0; in_valid = 1'b0;
      step();
      load(8'd2, 16'b111, 3, 16'd1, 16'd2, 16'd3);
      wait_done("reload_done_seen", 40);
      check("reload_bank0", bank[0], 16'd1);
      check("reload_bank1", bank[1], 16'd2);
      check("reload_bank2", bank[2], 16'd3);
      check("reload_ce", last_ce, 2);

      // One fire, then in_valid low.
      start = 1'b1; compute_len = 8'd2; in_valid = 1'b1; in_data = 16'h0055;
      step();
      start = 1'b0;
      step();
      in_valid = 1'b0;
`ifdef REG_LOAD_TIMEOUT_EN
      begin
         bit seen = 0;
         int i = 0;
         while (!seen && i < 40) begin
            @(negedge clk);
            if (err === 1'b1) seen = 1;
            i++;
         end
         check("timeout_err_seen", seen, 1);
         step();
         check("timeout_idle", busy, 0);
      end
`else
      repeat (40) step();
      check("stall_busy", busy, 1);
      check("stall_ready", in_ready, 1);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_load_ctrl.md
Name: reg_bank_load_ctrl

Overview:
Sequencer for a bank of NUM_REGS weight/ifmap holding registers inside a PE. Each register is a `set_reg`-gated D-register.
- On `start`, the block accepts NUM_REGS words over a valid/ready stream and steers each word to one register with a one-hot `set_reg` strobe.
- It then asserts `compute_en` for a programmed number of cycles, reports completion and returns to idle.

Parameters:
- DATA_WIDTH, 16: width of each stored word (signed, passed through unmodified).
- NUM_REGS, 3: number of registers in the bank (>=1).
- CNT_WIDTH, 8: width of the compute-cycle count input.
- TO_WIDTH, 4: timeout counter width; used only with REG_LOAD_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one load+compute pass; sampled only in IDLE.
- compute_len  input  CNT_WIDTH  compute cycles; captured when start is accepted.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_WIDTH  upstream word (signed).
- in_ready  output  1  block can accept a word this cycle.
- reg_in  output  DATA_WIDTH  data to the register bank; equals in_data, combinational.
- set_reg  output  NUM_REGS  one-hot write strobe; bit k loads register k this edge.
- compute_en  output  1  datapath may consume the register contents.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at end of pass.
- err  output  1  one-cycle pulse on timeout abort; tied 0 without the macro.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, idx=0, cycle counter=0, compute_en=0, done=0, err=0, busy=0. Combinational outputs evaluate to in_ready=0, set_reg=0.
- States: IDLE, LOAD, COMPUTE, DONE. Encoding is free.
- IDLE:
  - in_ready=0, set_reg=0.
  - start=1 -> latch compute_len into len_q, idx=0, go to LOAD.
- LOAD:
  - in_ready=1, combinational.
  - Handshake fires when in_valid && in_ready. Then set_reg = one-hot(idx), combinational, same cycle; otherwise set_reg=0.
  - Each fire: idx++.
  - Fire with idx==NUM_REGS-1 -> idx=0, go to COMPUTE.
  - Exactly NUM_REGS fires per pass; register k receives the k-th accepted word.
  - in_valid low stalls indefinitely (no timeout unless the macro is defined).
- COMPUTE:
  - compute_en=1 (registered; rises the cycle after the last fire). Counter counts 0..len_q-1.
  - After len_q cycles with compute_en high, go to DONE.
  - len_q==0: COMPUTE lasts exactly 1 cycle with compute_en=0, then DONE.
- DONE:
  - done=1 for one cycle, compute_en=0, busy=1; next state IDLE.
  - start high in DONE is ignored. A new pass may start in the first IDLE cycle.
- start while busy: ignored. compute_len changes while busy: no effect.
- Latency: start at cycle T, with in_valid held high:
  - LOAD occupies T+1..T+NUM_REGS.
  - compute_en is high T+NUM_REGS+1 .. T+NUM_REGS+len_q.
  - done pulses at T+NUM_REGS+len_q+1.
- set_reg is never multi-hot and never asserted outside LOAD.
- Reset mid-pass: immediately to IDLE, all outputs to reset values. Partially loaded registers keep their contents; no roll-back.

Optional Feature:
Macro: REG_LOAD_TIMEOUT_EN.
- Defined:
  - In LOAD, a TO_WIDTH-bit counter increments every cycle without a fire and clears on each fire.
  - When it reaches 2^TO_WIDTH-1 with no fire that cycle, the block pulses err for one cycle, sets idx=0 and goes to IDLE. done does not pulse and compute_en stays 0.
  - The timeout counter clears on entry to LOAD.
- Not defined: no timeout logic, err tied 0, LOAD waits forever.

Test Plan:
- Basic pass: reset, NUM_REGS=3, compute_len=4, start, words 5,-7,100 with in_valid always high -> set_reg 001,010,100 on consecutive cycles with reg_in 5,-7,100. Then compute_en high exactly 4 cycles, done pulse 1 cycle, busy low after.
- Backpressure gaps: in_valid toggled 1,0,0,1,0,1 -> set_reg asserted only on the 3 valid cycles, in order; compute starts the cycle after the third.
- compute_len=0 -> compute_en never high; done pulses 1 cycle after COMPUTE entry (NUM_REGS+2 cycles after start).
- start held high continuously with compute_len=2 -> second pass begins only in the IDLE cycle after done. Changing compute_len to 9 mid-pass does not alter the current pass (still 2 cycles).
- Async reset asserted after the second fire of a pass -> set_reg, in_ready, busy, compute_en drop immediately without waiting for a clock edge. The next start reloads from register 0.
- With REG_LOAD_TIMEOUT_EN, TO_WIDTH=4: start, one fire, then in_valid=0 -> err pulses after 15 idle cycles, state IDLE, no done. Without the macro, the same stimulus keeps busy=1 and in_ready=1 indefinitely.
